// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: buffers dispatched ops, tracks operand wakeups, fires the oldest ready op.
// Optional SPEC_WAKE_EN: a firing entry also wakes its dst preg at the same edge (back-to-back issue).
module issue_scheduler #(
  parameter int NUM_ENTRIES = 8,
  parameter int PREG_W      = 6,
  parameter int PKT_W       = 128
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [PKT_W-1:0]                   disp_pkt,
  input  logic [PREG_W-1:0]                  disp_src1_preg,
  input  logic [PREG_W-1:0]                  disp_src2_preg,
  input  logic                               disp_src1_rdy,
  input  logic                               disp_src2_rdy,
  input  logic [PREG_W-1:0]                  disp_dst_preg,
  input  logic                               wake_valid,
  input  logic [PREG_W-1:0]                  wake_preg,
  input  logic                               flush,
  input  logic                               stall,
  output logic                               fire_valid,
  output logic [PKT_W-1:0]                   fire_pkt,
  output logic [PREG_W-1:0]                  fire_src1_preg,
  output logic [PREG_W-1:0]                  fire_src2_preg,
  output logic [PREG_W-1:0]                  fire_dst_preg,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES+1);

  logic [NUM_ENTRIES-1:0]                   vld, rdy1, rdy2, elig, hit1, hit2;
  // older_than[i][j] = 1 when entry j was dispatched before entry i
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]  older_than;
  logic [NUM_ENTRIES-1:0][PKT_W-1:0]        pkt_q;
  logic [NUM_ENTRIES-1:0][PREG_W-1:0]       src1_q, src2_q, dst_q;
  logic [IDX_W-1:0]                         alloc_idx, sel_idx;
  logic                                     any_elig, fire_go, disp_go, int_wake;
  logic                                     disp_hit1, disp_hit2;

  always_comb begin
    elig      = vld & rdy1 & rdy2;
    any_elig  = |elig;
    fire_go   = any_elig & ~stall & ~flush;
`ifdef SPEC_WAKE_EN
    int_wake  = fire_go;
`else
    int_wake  = 1'b0;
`endif
    sel_idx   = '0;
    alloc_idx = '0;
    occupancy = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      // ages form a total order, so exactly one eligible entry has no older eligible peer
      if (elig[i] && ((elig & older_than[i]) == '0)) sel_idx = IDX_W'(i);
      if (!vld[i]) alloc_idx = IDX_W'(i);
      occupancy = occupancy + OCC_W'(vld[i]);
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit1[i] = (wake_valid && wake_preg == src1_q[i]) || (int_wake && dst_q[sel_idx] == src1_q[i]);
      hit2[i] = (wake_valid && wake_preg == src2_q[i]) || (int_wake && dst_q[sel_idx] == src2_q[i]);
    end
    disp_hit1  = (wake_valid && wake_preg == disp_src1_preg) || (int_wake && dst_q[sel_idx] == disp_src1_preg);
    disp_hit2  = (wake_valid && wake_preg == disp_src2_preg) || (int_wake && dst_q[sel_idx] == disp_src2_preg);
    disp_ready = (occupancy != OCC_W'(NUM_ENTRIES));
    disp_go    = disp_valid & disp_ready & ~flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld        <= '0;
      rdy1       <= '0;
      rdy2       <= '0;
      older_than <= '0;
      pkt_q      <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (hit1[i]) rdy1[i] <= 1'b1;
        if (hit2[i]) rdy2[i] <= 1'b1;
        if (fire_go && sel_idx == IDX_W'(i)) vld[i] <= 1'b0;
      end
      if (disp_go) begin
        vld[alloc_idx]    <= 1'b1;
        rdy1[alloc_idx]   <= disp_src1_rdy | disp_hit1;
        rdy2[alloc_idx]   <= disp_src2_rdy | disp_hit2;
        pkt_q[alloc_idx]  <= disp_pkt;
        src1_q[alloc_idx] <= disp_src1_preg;
        src2_q[alloc_idx] <= disp_src2_preg;
        dst_q[alloc_idx]  <= disp_dst_preg;
        // new entry is youngest; clearing its column drops stale age from a previous occupant
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (IDX_W'(i) == alloc_idx) older_than[i] <= vld;
          else                        older_than[i][alloc_idx] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_valid     <= 1'b0;
      fire_pkt       <= '0;
      fire_src1_preg <= '0;
      fire_src2_preg <= '0;
      fire_dst_preg  <= '0;
    end else if (flush) begin
      fire_valid <= 1'b0;
    end else if (!stall) begin
      fire_valid <= any_elig;
      if (any_elig) begin
        fire_pkt       <= pkt_q[sel_idx];
        fire_src1_preg <= src1_q[sel_idx];
        fire_src2_preg <= src2_q[sel_idx];
        fire_dst_preg  <= dst_q[sel_idx];
      end
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: expected fires are queued at dispatch, popped by a fire monitor.
module tb_issue_scheduler;
  localparam int N  = 8;
  localparam int PW = 6;
  localparam int KW = 128;
  localparam int OW = $clog2(N+1);

  logic clk = 1'b0, rst = 1'b0;
  logic disp_valid = 1'b0, disp_ready;
  logic [KW-1:0] disp_pkt = '0;
  logic [PW-1:0] disp_src1_preg = '0, disp_src2_preg = '0, disp_dst_preg = '0;
  logic disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
  logic wake_valid = 1'b0;
  logic [PW-1:0] wake_preg = '0;
  logic flush = 1'b0, stall = 1'b0;
  logic fire_valid;
  logic [KW-1:0] fire_pkt;
  logic [PW-1:0] fire_src1_preg, fire_src2_preg, fire_dst_preg;
  logic [OW-1:0] occupancy;

  typedef struct packed { logic [KW-1:0] pkt; logic [PW-1:0] src1; logic [PW-1:0] dst; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int vecs = 0, errs = 0, cyc = 0, fire_cyc = -1;
  logic last_stall = 1'b0;

  issue_scheduler #(.NUM_ENTRIES(N), .PREG_W(PW), .PKT_W(KW)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pkt(disp_pkt),
    .disp_src1_preg(disp_src1_preg), .disp_src2_preg(disp_src2_preg),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy), .disp_dst_preg(disp_dst_preg),
    .wake_valid(wake_valid), .wake_preg(wake_preg), .flush(flush), .stall(stall),
    .fire_valid(fire_valid), .fire_pkt(fire_pkt), .fire_src1_preg(fire_src1_preg),
    .fire_src2_preg(fire_src2_preg), .fire_dst_preg(fire_dst_preg), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    last_stall <= stall;
  end

  // a fire is new whenever fire_valid is high after an edge that was not stalled
  always @(negedge clk) begin
    if (rst && fire_valid && !last_stall) begin
      fire_cyc = cyc;
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_fire got pkt=%h dst=%0d, none expected", fire_pkt, fire_dst_preg);
      end else begin
        mon_e = exp_q.pop_front();
        if (fire_pkt !== mon_e.pkt || fire_src1_preg !== mon_e.src1 || fire_dst_preg !== mon_e.dst) begin
          errs++;
          $display("FAIL fire_order got pkt=%h src1=%0d dst=%0d, want pkt=%h src1=%0d dst=%0d",
                   fire_pkt, fire_src1_preg, fire_dst_preg, mon_e.pkt, mon_e.src1, mon_e.dst);
        end
      end
    end
  end

  function automatic logic [KW-1:0] mkpkt(input int id);
    return {32'hC0DE_0000 | 32'(id), 32'(id * 7), 32'hFACE_0001, 32'(id)};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input int id, input int s1, input bit r1, input int s2, input bit r2, input int dst);
    disp_valid     = 1'b1;
    disp_pkt       = mkpkt(id);
    disp_src1_preg = PW'(s1);
    disp_src1_rdy  = r1;
    disp_src2_preg = PW'(s2);
    disp_src2_rdy  = r2;
    disp_dst_preg  = PW'(dst);
  endtask

  task automatic disp1(input int id, input int s1, input bit r1, input int s2, input bit r2, input int dst);
    drv(id, s1, r1, s2, r2, dst);
    step();
    disp_valid = 1'b0;
  endtask

  task automatic expect_fire(input int id, input int s1, input int dst);
    exp_t e;
    e.pkt  = mkpkt(id);
    e.src1 = PW'(s1);
    e.dst  = PW'(dst);
    exp_q.push_back(e);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    chk_int("reset_fire_valid", int'(fire_valid), 0);
    chk_int("reset_occupancy", int'(occupancy), 0);
    chk_int("reset_disp_ready", int'(disp_ready), 1);
    vecs++;
    if (fire_pkt !== '0) begin errs++; $display("FAIL reset_fire_pkt got %h want 0", fire_pkt); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_min_latency();
    int c0;
    c0 = cyc;
    expect_fire(1, 3, 10);
    disp1(1, 3, 1, 4, 1, 10);
    chk_int("lat_occ_after_disp", int'(occupancy), 1);
    step();
    chk_int("lat_fire_valid", int'(fire_valid), 1);
    chk_int("lat_fire_cycle", fire_cyc, c0 + 2);
    chk_int("lat_occ_after_fire", int'(occupancy), 0);
    step();
    chk_int("lat_idle_fire_valid", int'(fire_valid), 0);
    vecs++;
    if (fire_pkt !== mkpkt(1)) begin errs++; $display("FAIL lat_payload_hold got %h want %h", fire_pkt, mkpkt(1)); end
  endtask

  task automatic test_wakeup_order();
    int w;
    expect_fire(3, 7, 12);
    expect_fire(2, 10, 11);
    disp1(2, 10, 0, 5, 1, 11);
    disp1(3, 7, 1, 8, 1, 12);
    w = cyc;
    wake_valid = 1'b1;
    wake_preg  = 6'd10;
    step();
    wake_valid = 1'b0;
    chk_int("wake_c_fire_cycle", fire_cyc, w + 1);
    step();
    chk_int("wake_b_fire_cycle", fire_cyc, w + 2);
    // wakeup arriving in the dispatch cycle must be captured
    w = cyc;
    expect_fire(4, 20, 13);
    drv(4, 20, 0, 21, 1, 13);
    wake_valid = 1'b1;
    wake_preg  = 6'd20;
    step();
    disp_valid = 1'b0;
    wake_valid = 1'b0;
    step();
    chk_int("same_cycle_wake_fire", fire_cyc, w + 2);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    expect_fire(5, 3, 10);
`ifdef SPEC_WAKE_EN
    expect_fire(6, 10, 14);
`endif
    disp1(5, 3, 1, 4, 1, 10);
    disp1(6, 10, 0, 9, 1, 14);
    chk_int("b2b_producer_fire", fire_cyc, c0 + 2);
    step();
`ifdef SPEC_WAKE_EN
    chk_int("b2b_dependent_fire", fire_cyc, c0 + 3);
    chk_int("b2b_occ", int'(occupancy), 0);
`else
    step(); step();
    chk_int("b2b_dependent_waits", int'(occupancy), 1);
    chk_int("b2b_no_extra_fire", fire_cyc, c0 + 2);
    c0 = cyc;
    expect_fire(6, 10, 14);
    wake_valid = 1'b1;
    wake_preg  = 6'd10;
    step();
    wake_valid = 1'b0;
    step();
    chk_int("b2b_dependent_after_wake", fire_cyc, c0 + 2);
`endif
  endtask

  task automatic test_fill_wrap();
    int n;
    for (int i = 0; i < 3; i++) expect_fire(10 + i, 30 + i, 40 + i);
    for (int i = 0; i < 8; i++) disp1(10 + i, 30 + i, 0, 0, 1, 40 + i);
    chk_int("full_occupancy", int'(occupancy), 8);
    chk_int("full_disp_ready", int'(disp_ready), 0);
    for (int i = 0; i < 3; i++) begin
      wake_valid = 1'b1;
      wake_preg  = PW'(30 + i);
      step();
    end
    wake_valid = 1'b0;
    step(); step();
    chk_int("partial_drain_occ", int'(occupancy), 5);
    // refill freed low slots with younger entries so age must beat index order
    for (int k = 0; k < 3; k++) disp1(18 + k, 60 + k, 0, 0, 1, 50 + k);
    stall = 1'b1;
    for (int i = 7; i >= 3; i--) begin
      wake_valid = 1'b1;
      wake_preg  = PW'(30 + i);
      step();
    end
    for (int k = 2; k >= 0; k--) begin
      wake_valid = 1'b1;
      wake_preg  = PW'(60 + k);
      step();
    end
    wake_valid = 1'b0;
    chk_int("stalled_full_occ", int'(occupancy), 8);
    chk_int("stalled_full_ready", int'(disp_ready), 0);
    for (int i = 3; i < 8; i++) expect_fire(10 + i, 30 + i, 40 + i);
    for (int k = 0; k < 3; k++) expect_fire(18 + k, 60 + k, 50 + k);
    stall = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk_int("drain_one_per_cycle", n, 8);
  endtask

  task automatic test_stall();
    logic fv;
    logic [KW-1:0] fp;
    stall = 1'b1;
    fv = fire_valid;
    fp = fire_pkt;
    disp1(21, 3, 1, 4, 1, 15);
    disp1(22, 3, 1, 4, 1, 16);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_int("stall_fire_valid_frozen", int'(fire_valid), int'(fv));
      chk_int("stall_occ_frozen", int'(occupancy), 2);
      vecs++;
      if (fire_pkt !== fp) begin errs++; $display("FAIL stall_pkt_frozen got %h want %h", fire_pkt, fp); end
    end
    expect_fire(21, 3, 15);
    expect_fire(22, 3, 16);
    stall = 1'b0;
    step();
    chk_int("stall_release_occ", int'(occupancy), 1);
    step();
    chk_int("stall_drained", exp_q.size(), 0);
  endtask

  task automatic test_flush();
    expect_fire(23, 3, 17);
    disp1(23, 3, 1, 4, 1, 17);
    drv(24, 3, 1, 4, 1, 18);
    step();
    chk_int("pre_flush_fire_valid", int'(fire_valid), 1);
    drv(25, 3, 1, 4, 1, 19);
    flush = 1'b1;
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    chk_int("flush_occ", int'(occupancy), 0);
    chk_int("flush_fire_valid", int'(fire_valid), 0);
    vecs++;
    if (fire_pkt !== mkpkt(23)) begin errs++; $display("FAIL flush_payload got %h want %h", fire_pkt, mkpkt(23)); end
    step(); step(); step();
    chk_int("flush_stays_empty", int'(occupancy), 0);
  endtask

  task automatic test_async_reset();
    disp1(26, 63, 0, 0, 1, 20);
    chk_int("pre_areset_occ", int'(occupancy), 1);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk_int("areset_occ", int'(occupancy), 0);
    chk_int("areset_ready", int'(disp_ready), 1);
    chk_int("areset_fire_valid", int'(fire_valid), 0);
    vecs++;
    if (fire_pkt !== '0) begin errs++; $display("FAIL areset_fire_pkt got %h want 0", fire_pkt); end
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_wakeup_order();
    test_back_to_back();
    test_fill_wrap();
    test_stall();
    test_flush();
    test_async_reset();
    chk_int("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
Out-of-order issue queue that sits between dispatch and register read. It buffers dispatched instructions, tracks source-operand readiness from writeback wakeup broadcasts, and each cycle selects the oldest fully-ready entry. That entry is fired to register read as a registered fire_valid/packet pair. This block sequences all traffic into the register-read/forwarding datapath.

Parameters:
NUM_ENTRIES, 8, queue depth (power of two, >=2)
PREG_W, 6, physical register index width
PKT_W, 128, opaque payload width (opcode, imm, pc, rob idx, etc.)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
disp_valid  in  1  dispatch request
disp_ready  out  1  queue can accept this cycle
disp_pkt  in  PKT_W  payload
disp_src1_preg / disp_src2_preg  in  PREG_W  source pregs
disp_src1_rdy / disp_src2_rdy  in  1  source already available at dispatch
disp_dst_preg  in  PREG_W  destination preg
wake_valid  in  1  writeback wakeup broadcast
wake_preg  in  PREG_W  preg being written
flush  in  1  squash all entries (branch mispredict)
stall  in  1  register read cannot accept a new fire
fire_valid  out  1  registered issue valid
fire_pkt  out  PKT_W  issued payload
fire_src1_preg / fire_src2_preg / fire_dst_preg  out  PREG_W  issued regs
occupancy  out  $clog2(NUM_ENTRIES+1)  valid entry count

Behaviour:
- Reset: all entries invalid. fire_valid=0, fire_pkt/fire_*_preg=0, occupancy=0, disp_ready=1.
- disp_ready = (occupancy != NUM_ENTRIES), computed from registered state only. Same-cycle frees give no credit.
- Dispatch (disp_valid & disp_ready): writes a free entry at the edge and records age as youngest.
  - Source ready bit = disp_srcN_rdy | (wake_valid & wake_preg==disp_srcN_preg). Same-cycle wakeup must not be lost.
- Wakeup: every valid entry with srcN_preg==wake_preg sets srcN_rdy at the edge. Multiple matches are all set. Wakeup of an already-ready source has no effect.
- Eligible: entry is valid and both rdy bits are 1, evaluated on registered state. An entry woken in cycle N is eligible in N+1.
- Select: oldest eligible entry in dispatch order. Age is tracked with an age matrix or equivalent, so ordering is exact across wrap and interleaved frees.
- Fire, at the edge with stall=0:
  - fire_valid <= any eligible.
  - If an entry is selected, fire_* outputs <= its fields and the entry is freed.
  - If none is eligible, fire_valid <= 0 and the payload holds.
- stall=1: fire outputs hold their values, no entry is freed, and dispatch and wakeup still proceed.
- Minimum latency: a dispatch with both sources ready in cycle N gives fire_valid=1 after edge N+1.
- Simultaneous dispatch and fire in the same cycle: occupancy unchanged. An entry freed at an edge may be re-allocated from the next cycle onward.
- Flush: has priority over dispatch, wakeup and fire. At the edge all entries become invalid, occupancy=0 and fire_valid=0 (payload unchanged).
- Asynchronous reset mid-operation forces the reset state immediately.

Optional Feature:
SPEC_WAKE_EN
- Defined: an entry firing at an edge also acts as an internal wakeup for its dst_preg at that same edge, ORed with the external wakeup. This applies to queued entries and to a same-cycle dispatch. A dependent instruction can therefore fire the cycle after its producer (back-to-back single-cycle ALU).
- Not defined: readiness comes only from disp_srcN_rdy and wake_*. Dependents fire at least one cycle after the external wake.

Test Plan:
- Reset, then dispatch A (src 3,4 ready, dst 10) at cycle 0 -> fire_valid=1 with A's payload after edge 1; occupancy returns to 0.
- Dispatch B (src1=10 not ready), then C (ready), then wake_preg=10 -> C fires first, then B. Without SPEC_WAKE_EN, B fires at wake+2 or later.
- With SPEC_WAKE_EN: dispatch A (dst 10, ready) and D (src1=10) -> A fires at edge k, D fires at edge k+1.
- Fill 8 entries, all not ready -> disp_ready=0 and occupancy=8. Wake all sources -> entries issue in dispatch order, one per cycle, across index wrap.
- Hold stall=1 for 3 cycles with 2 ready entries -> fire outputs frozen and occupancy unchanged. Release stall -> oldest issues.
- flush asserted together with disp_valid and an eligible entry -> next cycle occupancy=0, fire_valid=0, dispatched instruction dropped.
